// File: rtl/cache_line_fill_engine_pkg.sv
// rtl/cache_line_fill_engine_pkg.sv - shared state encoding and geometry helpers for the line fill engine
package cache_line_fill_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WORD_WR,
    ST_WR_DONE,
    ST_EVICT,
    ST_FILL,
    ST_FILL_DONE
  } state_t;

  function automatic int tag_bits_of(input int addr_bits, input int index_bits, input int block_offset);
    return addr_bits - index_bits - block_offset;
  endfunction

  function automatic int line_bits_of(input int block_offset);
    return 8 * (2 ** block_offset);
  endfunction

  function automatic int words_per_line_of(input int block_offset, input int word_size);
    return line_bits_of(block_offset) / word_size;
  endfunction

  // Byte-within-word offset width; the word index field sits directly above it.
  function automatic int byte_off_bits_of(input int word_size);
    return $clog2(word_size / 8);
  endfunction

endpackage

// File: rtl/cache_line_fill_engine_line_beat_counter.sv
// rtl/cache_line_fill_engine_line_beat_counter.sv - word index within a line, advanced once per completed beat
module cache_line_fill_engine_line_beat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

  // Line length is a power of two, so the final beat is the all-ones index.
  assign last = &count;

endmodule

// File: rtl/cache_line_fill_engine.sv
// rtl/cache_line_fill_engine.sv - line refill / dirty eviction / single word write sequencer on a word-wide bus
module cache_line_fill_engine
  import cache_line_fill_engine_pkg::*;
#(
  parameter int WORD_SIZE      = 32,
  parameter int ADDR_BITS      = 32,
  parameter int INDEX_BITS     = 5,
  parameter int BLOCK_OFFSET   = 6,
  parameter int TAG_BITS       = tag_bits_of(ADDR_BITS, INDEX_BITS, BLOCK_OFFSET),
  parameter int LINE_BITS      = line_bits_of(BLOCK_OFFSET),
  parameter int WORDS_PER_LINE = words_per_line_of(BLOCK_OFFSET, WORD_SIZE),
  parameter bit WRITE_BACK     = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 re,
  input  logic                 wr,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic                 victim_dirty,
  input  logic [TAG_BITS-1:0]  victim_tag,
  input  logic [LINE_BITS-1:0] victim_line,
  output logic [LINE_BITS-1:0] fill_line,
  output logic [TAG_BITS-1:0]  fill_tag,
  output logic                 full_line_wr,
  output logic                 re_ack,
  output logic                 wr_ack,
  output logic [ADDR_BITS-1:0] ext_addr,
  output logic [WORD_SIZE-1:0] ext_data_out,
  input  logic [WORD_SIZE-1:0] ext_data_in,
  output logic                 ext_re,
  output logic                 ext_wr,
  input  logic                 ext_ack,
  output logic                 busy
);

  localparam int CNT_W  = $clog2(WORDS_PER_LINE);
  localparam int BYTE_W = byte_off_bits_of(WORD_SIZE);

  state_t                     state, state_n;
  logic [ADDR_BITS-1:BYTE_W]  cap_addr;
  logic [WORD_SIZE-1:0]       cap_wdata;
  logic [TAG_BITS-1:0]        cap_vtag;
  logic [LINE_BITS-1:0]       cap_vline;
  logic [CNT_W-1:0]           cnt;
  logic                       cnt_last;
  logic                       beat;
  logic                       accept;
  logic [TAG_BITS-1:0]        cap_tag;
  logic [INDEX_BITS-1:0]      cap_index;

  assign cap_tag   = cap_addr[ADDR_BITS-1 -: TAG_BITS];
  assign cap_index = cap_addr[BLOCK_OFFSET +: INDEX_BITS];
  assign accept    = (state == ST_IDLE) && (re || wr);
  assign beat      = (ext_re || ext_wr) && ext_ack;

  cache_line_fill_engine_line_beat_counter #(
    .CNT_W (CNT_W)
  ) u_beat_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (!enable || (state == ST_IDLE)),
    .inc   (beat && ((state == ST_EVICT) || (state == ST_FILL))),
    .count (cnt),
    .last  (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (wr) begin
          state_n = ST_WORD_WR;
        end else if (re) begin
          state_n = (WRITE_BACK && victim_dirty) ? ST_EVICT : ST_FILL;
        end
      end
      ST_WORD_WR:   if (beat) state_n = ST_WR_DONE;
      ST_WR_DONE:   state_n = ST_IDLE;
      ST_EVICT:     if (beat && cnt_last) state_n = ST_FILL;
      ST_FILL:      if (beat && cnt_last) state_n = ST_FILL_DONE;
      ST_FILL_DONE: state_n = ST_IDLE;
      default:      state_n = ST_IDLE;
    endcase
  end

  // Abort clears everything so a partially assembled line is never visible.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_vtag  <= '0;
      cap_vline <= '0;
      fill_line <= '0;
      fill_tag  <= '0;
    end else begin
      if (accept) begin
        cap_addr  <= addr[ADDR_BITS-1:BYTE_W];
        cap_wdata <= wr_data;
        cap_vtag  <= victim_tag;
        cap_vline <= victim_line;
      end
      if ((state == ST_FILL) && beat) begin
        fill_line[int'(cnt)*WORD_SIZE +: WORD_SIZE] <= ext_data_in;
        if (cnt_last) begin
          fill_tag <= cap_tag;
        end
      end
    end
  end

  // Bus outputs decode from registered state only, so ext_ack never reaches them combinationally.
  always_comb begin
    ext_re       = 1'b0;
    ext_wr       = 1'b0;
    ext_addr     = '0;
    ext_data_out = '0;
    case (state)
      ST_WORD_WR: begin
        ext_wr       = 1'b1;
        ext_addr     = {cap_addr, {BYTE_W{1'b0}}};
        ext_data_out = cap_wdata;
      end
      ST_EVICT: begin
        ext_wr       = 1'b1;
        ext_addr     = {cap_vtag, cap_index, cnt, {BYTE_W{1'b0}}};
        ext_data_out = cap_vline[int'(cnt)*WORD_SIZE +: WORD_SIZE];
      end
      ST_FILL: begin
        ext_re   = 1'b1;
        ext_addr = {cap_tag, cap_index, cnt, {BYTE_W{1'b0}}};
      end
      default: ;
    endcase
  end

  assign wr_ack       = (state == ST_WR_DONE);
  assign re_ack       = (state == ST_FILL_DONE);
  assign full_line_wr = (state == ST_FILL_DONE);
  assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_cache_line_fill_engine.sv
// tb/tb_cache_line_fill_engine.sv - self-checking bench for cache_line_fill_engine
module tb_cache_line_fill_engine;

  localparam int WS  = 32;
  localparam int AB  = 32;
  localparam int TB  = 21;
  localparam int LB  = 512;
  localparam int WPL = 16;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] wr_data;
    bit          dirty;
    logic [20:0] vtag;
    int          exp_cycles;
    logic [31:0] exp_first_addr;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst, enable, re, wr, victim_dirty, ext_ack;
  logic [AB-1:0] addr;
  logic [WS-1:0] wr_data, ext_data_in;
  logic [TB-1:0] victim_tag;
  logic [LB-1:0] victim_line;
  logic [LB-1:0] fill_line;
  logic [TB-1:0] fill_tag;
  logic          full_line_wr, re_ack, wr_ack, ext_re, ext_wr, busy;
  logic [AB-1:0] ext_addr;
  logic [WS-1:0] ext_data_out;

  logic          re2, wr2, ext_ack2;
  logic [WS-1:0] ext_data_in2, ext_data_out2;
  logic [LB-1:0] fill_line2;
  logic [TB-1:0] fill_tag2;
  logic          full_line_wr2, re_ack2, wr_ack2, ext_re2, ext_wr2, busy2;
  logic [AB-1:0] ext_addr2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  assign ext_data_in  = mem_fn(ext_addr);
  assign ext_data_in2 = mem_fn(ext_addr2);

  cache_line_fill_engine dut (
    .clk(clk), .rst(rst), .enable(enable), .re(re), .wr(wr), .addr(addr), .wr_data(wr_data),
    .victim_dirty(victim_dirty), .victim_tag(victim_tag), .victim_line(victim_line),
    .fill_line(fill_line), .fill_tag(fill_tag), .full_line_wr(full_line_wr), .re_ack(re_ack),
    .wr_ack(wr_ack), .ext_addr(ext_addr), .ext_data_out(ext_data_out), .ext_data_in(ext_data_in),
    .ext_re(ext_re), .ext_wr(ext_wr), .ext_ack(ext_ack), .busy(busy)
  );

  cache_line_fill_engine #(.WRITE_BACK(1'b0)) dut_nwb (
    .clk(clk), .rst(rst), .enable(enable), .re(re2), .wr(wr2), .addr(addr), .wr_data(wr_data),
    .victim_dirty(victim_dirty), .victim_tag(victim_tag), .victim_line(victim_line),
    .fill_line(fill_line2), .fill_tag(fill_tag2), .full_line_wr(full_line_wr2), .re_ack(re_ack2),
    .wr_ack(wr_ack2), .ext_addr(ext_addr2), .ext_data_out(ext_data_out2), .ext_data_in(ext_data_in2),
    .ext_re(ext_re2), .ext_wr(ext_wr2), .ext_ack(ext_ack2), .busy(busy2)
  );

  task automatic chk(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_ctrl"}, {busy, ext_re, ext_wr, wr_ack, re_ack, full_line_wr, ext_addr, ext_data_out, fill_tag}, '0);
    chk({nm, "_line"}, fill_line, '0);
  endtask

  function automatic logic [31:0] line_addr(input logic [31:0] tag, input logic [31:0] idx, input int k);
    return (tag << 11) | (idx << 6) | (32'(k) << 2);
  endfunction

  function automatic logic [31:0] model_first(input vec_t v);
    if (v.is_wr) return v.addr & ~32'd3;
    if (v.dirty) return line_addr(32'(v.vtag), (v.addr >> 6) & 32'd31, 0);
    return line_addr(v.addr >> 11, (v.addr >> 6) & 32'd31, 0);
  endfunction

  function automatic logic [LB-1:0] model_line(input logic [31:0] a);
    logic [LB-1:0] l;
    for (int k = 0; k < WPL; k++) l[k*WS +: WS] = mem_fn(line_addr(a >> 11, (a >> 6) & 32'd31, k));
    return l;
  endfunction

  task automatic do_req(input vec_t v, input bit ack_always);
    bit qw[$];
    logic [31:0] qa[$];
    logic [31:0] qd[$];
    logic [31:0] tag, idx, first_addr, pa, pd, a;
    bit pend, pw, got_first, done;
    int cyc;
    tag = v.addr >> 11;
    idx = (v.addr >> 6) & 32'd31;
    if (v.is_wr) begin
      qw.push_back(1'b1); qa.push_back(v.addr & ~32'd3); qd.push_back(v.wr_data);
    end else begin
      if (v.dirty)
        for (int k = 0; k < WPL; k++) begin
          qw.push_back(1'b1); qa.push_back(line_addr(32'(v.vtag), idx, k)); qd.push_back(victim_line[k*WS +: WS]);
        end
      for (int k = 0; k < WPL; k++) begin
        qw.push_back(1'b0); qa.push_back(line_addr(tag, idx, k)); qd.push_back(32'd0);
      end
    end
    @(negedge clk);
    addr = v.addr; wr_data = v.wr_data; victim_dirty = v.dirty; victim_tag = v.vtag;
    re = !v.is_wr; wr = v.is_wr; ext_ack = ack_always;
    cyc = 0; pend = 0; got_first = 0; done = 0; first_addr = '0; pw = 0; pa = '0; pd = '0;
    while (!done && cyc < 400) begin
      @(posedge clk); cyc++; #1;
      if (pend) chk("strobe_hold", {ext_wr, ext_re, ext_addr, ext_data_out}, {pw, !pw, pa, pd});
      pend = 0;
      if (wr_ack || re_ack) begin
        done = 1;
      end else begin
        ext_ack = ack_always ? 1'b1 : ($urandom_range(0, 2) != 0);
        if (ext_re || ext_wr) begin
          if (!got_first) begin first_addr = ext_addr; got_first = 1; end
          if (ext_ack) begin
            if (qa.size() == 0) begin
              chk("extra_beat", {ext_wr, ext_addr}, '0);
            end else begin
              chk("beat_type", ext_wr, qw.pop_front());
              a = qa.pop_front();
              chk("beat_addr", ext_addr, a);
              a = qd.pop_front();
              if (ext_wr) chk("beat_data", ext_data_out, a);
            end
          end else begin
            pend = 1; pw = ext_wr; pa = ext_addr; pd = ext_data_out;
          end
        end
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL req_timeout addr=%0h cycles=%0d", v.addr, cyc);
    end else begin
      if (ack_always && v.exp_cycles > 0) chk("latency", cyc + 1, v.exp_cycles);
      chk("first_addr", first_addr, v.exp_first_addr);
      chk("beats_left", qa.size(), 0);
      if (v.is_wr) begin
        chk("wr_ack_flags", {wr_ack, re_ack, full_line_wr}, 3'b100);
      end else begin
        chk("re_ack_flags", {wr_ack, re_ack, full_line_wr}, 3'b011);
        chk("fill_line", fill_line, model_line(v.addr));
        chk("fill_tag", fill_tag, tag);
      end
    end
    re = 0; wr = 0; ext_ack = 0;
    @(posedge clk); #1;
    chk("post_idle", {busy, wr_ack, re_ack, full_line_wr}, 4'b0);
  endtask

  initial begin
    vec_t tbl[6];
    vec_t v;
    int n, cyc;
    bit seen;
    tbl[0] = '{0, 32'h0000_1234, 32'h0,          0, 21'h0,      18, 32'h0000_1200};
    tbl[1] = '{0, 32'h0000_0040, 32'h0,          1, 21'h7,      34, 32'h0000_3840};
    tbl[2] = '{1, 32'h0000_1006, 32'hDEAD_BEEF,  0, 21'h0,       3, 32'h0000_1004};
    tbl[3] = '{0, 32'hFFFF_FFFC, 32'h0,          0, 21'h5,      18, 32'hFFFF_FFC0};
    tbl[4] = '{0, 32'h8000_07C0, 32'h0,          1, 21'h1F_FFFF, 34, 32'hFFFF_FFC0};
    tbl[5] = '{1, 32'h0000_0003, 32'h1234_5678,  1, 21'h3,       3, 32'h0000_0000};

    rst = 1; enable = 1; re = 0; wr = 0; re2 = 0; wr2 = 0; ext_ack = 0; ext_ack2 = 1;
    addr = '0; wr_data = '0; victim_dirty = 0; victim_tag = '0;
    for (int k = 0; k < WPL; k++) victim_line[k*WS +: WS] = 32'h100 + 32'(k);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check_all_zero("reset");
    chk("reset_nwb", {busy2, ext_re2, ext_wr2, re_ack2, ext_addr2}, '0);

    for (int i = 0; i < 6; i++) do_req(tbl[i], 1'b1);

    // wr beats re when both are raised; re held through wr_ack starts a fill straight after
    @(negedge clk);
    addr = 32'h0000_0808; wr_data = 32'hCAFE_F00D; victim_dirty = 0; re = 1; wr = 1; ext_ack = 1;
    @(posedge clk); #1;
    chk("prio_word_wr", {ext_wr, ext_re, ext_addr}, {2'b10, 32'h0000_0808});
    @(posedge clk); #1;
    chk("prio_wr_ack", {wr_ack, re_ack}, 2'b10);
    wr = 0;
    @(posedge clk); #1;
    chk("prio_idle_gap", busy, 1'b0);
    @(posedge clk); #1;
    chk("prio_fill_start", {ext_re, ext_addr}, {1'b1, 32'h0000_0800});
    re = 0; seen = 0; cyc = 0;
    while (!seen && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      seen = re_ack;
    end
    chk("prio_fill_done", {seen, fill_line}, {1'b1, model_line(32'h0000_0808)});
    @(posedge clk); #1;

    // enable dropped during beat 5 aborts the fill without acks
    @(negedge clk);
    addr = 32'h0000_2000; victim_dirty = 0; re = 1; ext_ack = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_beat5", {ext_re, ext_addr}, {1'b1, 32'h0000_2014});
    enable = 0; re = 0;
    @(posedge clk); #1;
    check_all_zero("abort");
    enable = 1; seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      seen = seen | re_ack | full_line_wr | busy;
    end
    chk("abort_quiet", seen, 1'b0);
    v = '{0, 32'h0000_2000, 32'h0, 0, 21'h0, 18, 32'h0000_2000};
    do_req(v, 1'b1);

    // reset during the fourth eviction beat
    @(negedge clk);
    addr = 32'h0000_0040; victim_dirty = 1; victim_tag = 21'h7; re = 1; ext_ack = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_evict_beat3", {ext_wr, ext_addr, ext_data_out}, {1'b1, 32'h0000_384C, 32'h0000_0103});
    rst = 1; re = 0;
    @(posedge clk); #1;
    check_all_zero("rst_evict");
    rst = 0; ext_ack = 0;

    // no-write-back build never evicts even with a dirty victim
    @(negedge clk);
    addr = 32'h0000_1234; victim_dirty = 1; victim_tag = 21'h9; re2 = 1;
    n = 0; cyc = 0; seen = 0;
    while (!seen && cyc < 60) begin
      @(posedge clk); #1; cyc++;
      if (ext_wr2) n++;
      seen = re_ack2;
    end
    re2 = 0;
    chk("nwb_no_evict", n, 0);
    chk("nwb_latency", {seen, 32'(cyc + 1)}, {1'b1, 32'd18});
    chk("nwb_fill_line", fill_line2, model_line(32'h0000_1234));
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) begin
      v.is_wr = ($urandom_range(0, 3) == 0);
      v.addr = $urandom; v.wr_data = $urandom; v.dirty = $urandom_range(0, 1);
      v.vtag = 21'($urandom); v.exp_cycles = 0;
      v.exp_first_addr = model_first(v);
      for (int k = 0; k < WPL; k++) victim_line[k*WS +: WS] = $urandom;
      do_req(v, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
